// File: rtl/jtdd2_mcu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : jtdd2_mcu_ctrl_pkg                                               |
// | Purpose : Shared definitions for the DD2 main-CPU / MCU link controller:   |
// |           control-latch bit positions, arbiter state encoding and status  |
// |           register bit positions.                                          |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package jtdd2_mcu_ctrl_pkg;

   // Control latch bit positions (main CPU data bus)
   localparam int CTL_RSTB = 0;   // MCU reset, active low
   localparam int CTL_HALT = 1;   // software halt request
   localparam int CTL_NMI  = 2;   // NMI trigger, rising edge between writes
   localparam int CTL_AUTO = 3;   // automatic halt on shared-RAM access

   // Status register bit positions
   localparam int ST_BAN  = 0;    // ~mcu_ban : MCU is halted
   localparam int ST_AUTO = 1;    // auto-halt enabled
   localparam int ST_IRQ  = 2;    // MCU interrupt pending
   localparam int ST_TMO  = 3;    // sticky grant timeout

   // Bus-request arbiter states
   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_REQ   = 3'd1,
      ARB_GRANT = 3'd2,
      ARB_HOLD  = 3'd3,
      ARB_ABORT = 3'd4
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/jtdd2_mcu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtdd2_mcu_arb                                                    |
// | Purpose : Halt/grant arbiter. Requests the MCU bus when the main CPU hits  |
// |           the shared RAM window, stalls the main CPU until the MCU        |
// |           acknowledges, keeps the MCU halted for HOLD_CYC cycles after    |
// |           the last access and aborts the stall after TIMEOUT cycles.      |
// | Ports   : clk, rst        clock, asynchronous active-high reset            |
// |           i_cen           main CPU clock enable (all steps advance on it) |
// |           i_rstb          MCU reset latch (0 forces IDLE)                 |
// |           i_com_cs        main CPU access to shared RAM                   |
// |           i_mcu_ban       MCU bus acknowledge, active low                 |
// |           i_auto_en       auto-halt enable                                |
// |           i_sw_halt       software halt request                           |
// |           o_fsm_req       arbiter bus request                             |
// |           o_main_wait     main CPU stall                                  |
// |           o_timeout       one-cycle pulse when a stall is aborted         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtdd2_mcu_arb
   import jtdd2_mcu_ctrl_pkg::*;
#(
   parameter int HOLD_CYC = 8,
   parameter int TIMEOUT  = 1023
)(
   input  logic clk,
   input  logic rst,
   input  logic i_cen,
   input  logic i_rstb,
   input  logic i_com_cs,
   input  logic i_mcu_ban,
   input  logic i_auto_en,
   input  logic i_sw_halt,
   output logic o_fsm_req,
   output logic o_main_wait,
   output logic o_timeout
);

   localparam int TW = $clog2(TIMEOUT + 1);

   arb_state_t       r_state;
   arb_state_t       w_state_n;
   logic [TW-1:0]    r_tmo_cnt;
   logic [TW-1:0]    w_tmo_cnt_n;
   logic [7:0]       r_hold_cnt;
   logic [7:0]       w_hold_cnt_n;
   logic             w_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_tmo_cnt  <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_n;
         r_tmo_cnt  <= w_tmo_cnt_n;
         r_hold_cnt <= w_hold_cnt_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_tmo_cnt_n  = r_tmo_cnt;
      w_hold_cnt_n = r_hold_cnt;
      w_timeout    = 1'b0;
      if (!i_rstb) begin
         // MCU held in reset: nothing to arbitrate against
         w_state_n    = ARB_IDLE;
         w_tmo_cnt_n  = '0;
         w_hold_cnt_n = '0;
      end else if (i_cen) begin
         case (r_state)
            ARB_IDLE: begin
               if (i_com_cs) begin
                  if (!i_mcu_ban) begin
                     w_state_n = ARB_GRANT;
                  end else if (i_auto_en || !i_sw_halt) begin
                     w_state_n   = ARB_REQ;
                     w_tmo_cnt_n = '0;
                  end
                  // sw_halt without auto: the software request is already
                  // on the bus, just stall (comb wait) until it is granted
               end
            end
            ARB_REQ: begin
               if (!i_mcu_ban) begin
                  w_state_n = ARB_GRANT;
               end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                  // this cycle is the TIMEOUT-th spent waiting in REQ
                  w_state_n = ARB_ABORT;
                  w_timeout = 1'b1;
               end else begin
                  w_tmo_cnt_n = r_tmo_cnt + 1'b1;
               end
            end
            ARB_GRANT: begin
               if (i_mcu_ban) begin
                  // MCU resumed under us: request the bus again
                  w_state_n   = ARB_REQ;
                  w_tmo_cnt_n = '0;
               end else if (!i_com_cs) begin
                  w_state_n    = (HOLD_CYC == 0) ? ARB_IDLE : ARB_HOLD;
                  w_hold_cnt_n = 8'(HOLD_CYC);
               end
            end
            ARB_HOLD: begin
               if (i_mcu_ban) begin
                  w_state_n   = ARB_REQ;
                  w_tmo_cnt_n = '0;
               end else if (i_com_cs) begin
                  w_state_n = ARB_GRANT;
               end else if (r_hold_cnt <= 8'd1) begin
                  w_state_n    = ARB_IDLE;
                  w_hold_cnt_n = '0;
               end else begin
                  w_hold_cnt_n = r_hold_cnt - 1'b1;
               end
            end
            ARB_ABORT: begin
               if (!i_com_cs) w_state_n = ARB_IDLE;
            end
            default: w_state_n = ARB_IDLE;
         endcase
      end
   end

   assign o_fsm_req = (r_state == ARB_REQ) || (r_state == ARB_GRANT) ||
                      (r_state == ARB_HOLD);

   // Stall while waiting for grant; outside REQ the stall is combinational so
   // the very cycle that first touches the window (or sees the MCU resume)
   // is already held. An aborted access is not stalled, and no stall is
   // raised while the MCU sits in reset since it cannot contend for the RAM.
   assign o_main_wait = i_rstb &&
                        ((r_state == ARB_REQ) ||
                         (r_state != ARB_ABORT && i_com_cs && i_mcu_ban));

   assign o_timeout = w_timeout;

endmodule
`default_nettype wire

// File: rtl/jtdd2_mcu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtdd2_mcu_ctrl                                                   |
// | Purpose : Main-CPU-side controller of the DD2 sub-CPU link: MCU control    |
// |           latch (reset/halt/NMI/auto), bus-request arbitration for the    |
// |           shared RAM and MCU-to-main interrupt latch.                     |
// | Ports   : clk, rst         clock, asynchronous active-high reset           |
// |           i_main_cen       main CPU clock enable                          |
// |           i_ctl_cs         control latch select                           |
// |           i_main_wrn       main CPU write, active low                     |
// |           i_main_dout[7:0] b0 rstb, b1 halt, b2 NMI, b3 auto-halt         |
// |           i_com_cs         shared RAM access                              |
// |           i_mcu_ban        MCU bus acknowledge, active low                |
// |           i_mcu_irqmain    MCU interrupt request level                    |
// |           i_irq_ack        main CPU interrupt acknowledge                 |
// |           o_mcu_rstb       MCU reset, active low                          |
// |           o_mcu_halt       bus request to MCU                             |
// |           o_mcu_nmi_set    NMI pulse to MCU                               |
// |           o_main_wait      main CPU stall                                 |
// |           o_main_irq       interrupt to main CPU                          |
// |           o_status[7:0]    {4'b0, timeout, irq_pend, auto_en, ~mcu_ban}   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtdd2_mcu_ctrl
   import jtdd2_mcu_ctrl_pkg::*;
#(
   parameter int NMI_LEN  = 4,
   parameter int HOLD_CYC = 8,
   parameter int TIMEOUT  = 1023
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_main_cen,
   input  logic       i_ctl_cs,
   input  logic       i_main_wrn,
   input  logic [7:0] i_main_dout,
   input  logic       i_com_cs,
   input  logic       i_mcu_ban,
   input  logic       i_mcu_irqmain,
   input  logic       i_irq_ack,
   output logic       o_mcu_rstb,
   output logic       o_mcu_halt,
   output logic       o_mcu_nmi_set,
   output logic       o_main_wait,
   output logic       o_main_irq,
   output logic [7:0] o_status
);

   logic       r_rstb;
   logic       r_sw_halt;
   logic       r_auto_en;
   logic       r_nmi_bit;      // b2 as last written, for edge detection
   logic [3:0] r_nmi_cnt;
   logic       r_tmo_flag;
   logic       r_irq_d;
   logic       r_irq_pend;
   logic       r_main_irq;
   logic [7:0] r_status;

   logic       w_wr;
   logic       w_nmi_trig;
   logic       w_irq_rise;
   logic       w_fsm_req;
   logic       w_main_wait;
   logic       w_timeout;
   logic       w_unused_dout;

   assign w_wr = i_main_cen && i_ctl_cs && !i_main_wrn;

   // A 0->1 on b2 fires only if the same write keeps the MCU out of reset
   assign w_nmi_trig = w_wr && i_main_dout[CTL_NMI] && !r_nmi_bit &&
                       i_main_dout[CTL_RSTB];

   assign w_irq_rise = i_mcu_irqmain && !r_irq_d;

   assign w_unused_dout = ^i_main_dout[7:4];

   // Control latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstb    <= 1'b0;
         r_sw_halt <= 1'b0;
         r_auto_en <= 1'b0;
         r_nmi_bit <= 1'b0;
      end else if (w_wr) begin
         r_rstb    <= i_main_dout[CTL_RSTB];
         r_sw_halt <= i_main_dout[CTL_HALT];
         r_auto_en <= i_main_dout[CTL_AUTO];
         r_nmi_bit <= i_main_dout[CTL_NMI];
      end
   end

   // NMI pulse: fixed length, not retriggerable, killed by putting the MCU
   // into reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nmi_cnt <= '0;
      end else if (w_wr && !i_main_dout[CTL_RSTB]) begin
         r_nmi_cnt <= '0;
      end else if (w_nmi_trig && r_nmi_cnt == 4'd0) begin
         r_nmi_cnt <= 4'(NMI_LEN);
      end else if (i_main_cen && r_nmi_cnt != 4'd0) begin
         r_nmi_cnt <= r_nmi_cnt - 1'b1;
      end
   end

   // Sticky timeout flag; a new abort outranks a simultaneous clearing write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_flag <= 1'b0;
      end else if (w_timeout) begin
         r_tmo_flag <= 1'b1;
      end else if (w_wr) begin
         r_tmo_flag <= 1'b0;
      end
   end

   // MCU interrupt: edge detect every clk, set beats acknowledge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_d    <= 1'b0;
         r_irq_pend <= 1'b0;
         r_main_irq <= 1'b0;
      end else begin
         r_irq_d <= i_mcu_irqmain;
         if (w_irq_rise) begin
            r_irq_pend <= 1'b1;
         end else if (i_irq_ack) begin
            r_irq_pend <= 1'b0;
         end
         r_main_irq <= r_irq_pend;
      end
   end

   // Status is registered so it reads back all zeros while in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= '0;
      end else begin
         r_status           <= '0;
         r_status[ST_BAN]   <= !i_mcu_ban;
         r_status[ST_AUTO]  <= r_auto_en;
         r_status[ST_IRQ]   <= r_irq_pend;
         r_status[ST_TMO]   <= r_tmo_flag;
      end
   end

   jtdd2_mcu_arb #(
      .HOLD_CYC (HOLD_CYC),
      .TIMEOUT  (TIMEOUT)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_cen       (i_main_cen),
      .i_rstb      (r_rstb),
      .i_com_cs    (i_com_cs),
      .i_mcu_ban   (i_mcu_ban),
      .i_auto_en   (r_auto_en),
      .i_sw_halt   (r_sw_halt),
      .o_fsm_req   (w_fsm_req),
      .o_main_wait (w_main_wait),
      .o_timeout   (w_timeout)
   );

   assign o_mcu_rstb    = r_rstb;
   assign o_mcu_halt    = r_sw_halt | w_fsm_req;
   assign o_mcu_nmi_set = (r_nmi_cnt != 4'd0);
   assign o_main_wait   = w_main_wait;
   assign o_main_irq    = r_main_irq;
   assign o_status      = r_status;

endmodule
`default_nettype wire

// File: tb/tb_jtdd2_mcu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_jtdd2_mcu_ctrl                                                |
// | Purpose : Self-checking bench for jtdd2_mcu_ctrl. Expected values come    |
// |           from the link's rules (pulse lengths, stall lengths, IRQ       |
// |           set/clear priority) evaluated in the bench.                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jtdd2_mcu_ctrl;

   localparam int NMI_LEN  = 4;
   localparam int HOLD_CYC = 8;
   localparam int TIMEOUT  = 1023;

   logic       clk = 1'b0;
   logic       rst;
   logic       main_cen;
   logic       ctl_cs;
   logic       main_wrn;
   logic [7:0] main_dout;
   logic       com_cs;
   logic       mcu_ban;
   logic       mcu_irqmain;
   logic       irq_ack;
   logic       mcu_rstb;
   logic       mcu_halt;
   logic       mcu_nmi_set;
   logic       main_wait;
   logic       main_irq;
   logic [7:0] status;

   int total = 0;
   int bad   = 0;
   int gap   = 2;
   int cnt_nmi, cnt_wait, cnt_halt;
   logic s_wait, s_nmi, s_halt;

   always #5 clk = ~clk;

   jtdd2_mcu_ctrl #(
      .NMI_LEN  (NMI_LEN),
      .HOLD_CYC (HOLD_CYC),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_main_cen    (main_cen),
      .i_ctl_cs      (ctl_cs),
      .i_main_wrn    (main_wrn),
      .i_main_dout   (main_dout),
      .i_com_cs      (com_cs),
      .i_mcu_ban     (mcu_ban),
      .i_mcu_irqmain (mcu_irqmain),
      .i_irq_ack     (irq_ack),
      .o_mcu_rstb    (mcu_rstb),
      .o_mcu_halt    (mcu_halt),
      .o_mcu_nmi_set (mcu_nmi_set),
      .o_main_wait   (main_wait),
      .o_main_irq    (main_irq),
      .o_status      (status)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // One main_cen cycle after a random number of idle clocks. Outputs are
   // sampled mid-cycle (before the enabling edge) and tallied.
   task automatic cen_cyc();
      main_cen = 1'b0;
      repeat ($urandom_range(0, gap)) clk1();
      main_cen = 1'b1;
      #1;
      s_wait = main_wait;
      s_nmi  = mcu_nmi_set;
      s_halt = mcu_halt;
      cnt_wait += int'(s_wait);
      cnt_nmi  += int'(s_nmi);
      cnt_halt += int'(s_halt);
      @(posedge clk);
      #1;
      main_cen = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cen_cyc();
   endtask

   task automatic wr(input logic [7:0] d);
      ctl_cs    = 1'b1;
      main_wrn  = 1'b0;
      main_dout = d;
      cen_cyc();
      ctl_cs    = 1'b0;
      main_wrn  = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int   g_tab [4] = '{1, 2, 6, 0};
      int   g, n;
      logic m_b2, b2, m_pend, m_prev, in_v, ack_v, exp_irq;
      logic [7:0] d;

      rst = 1'b1; main_cen = 1'b0; ctl_cs = 1'b0; main_wrn = 1'b1;
      main_dout = 8'h00; com_cs = 1'b0; mcu_ban = 1'b1;
      mcu_irqmain = 1'b0; irq_ack = 1'b0;
      cnt_nmi = 0; cnt_wait = 0; cnt_halt = 0;
      repeat (3) clk1();

      // ---- reset state ----
      chk("rst_rstb",   32'(mcu_rstb),    32'd0);
      chk("rst_halt",   32'(mcu_halt),    32'd0);
      chk("rst_nmi",    32'(mcu_nmi_set), 32'd0);
      chk("rst_wait",   32'(main_wait),   32'd0);
      chk("rst_irq",    32'(main_irq),    32'd0);
      chk("rst_status", 32'(status),      32'h00);
      rst = 1'b0;
      clk1();

      // ---- release MCU from reset ----
      wr(8'h01);
      chk("wr01_rstb", 32'(mcu_rstb), 32'd1);
      chk("wr01_halt", 32'(mcu_halt), 32'd0);
      chk("wr01_irq",  32'(main_irq), 32'd0);
      clk1(); clk1();
      chk("status_ban1", 32'(status), 32'h00);
      mcu_ban = 1'b0;
      clk1(); clk1();
      chk("status_ban0", 32'(status), 32'h01);
      mcu_ban = 1'b1;
      clk1();

      // ---- NMI pulses ----
      cnt_nmi = 0; wr(8'h05); run(NMI_LEN + 4);
      chk("nmi_first", 32'(cnt_nmi), 32'(NMI_LEN));
      cnt_nmi = 0; wr(8'h05); run(NMI_LEN + 4);
      chk("nmi_repeat_no_edge", 32'(cnt_nmi), 32'd0);
      cnt_nmi = 0; wr(8'h01); wr(8'h05); run(NMI_LEN + 4);
      chk("nmi_01_05", 32'(cnt_nmi), 32'(NMI_LEN));
      wr(8'h01);
      cnt_nmi = 0; wr(8'h05); wr(8'h01); wr(8'h05); run(NMI_LEN + 4);
      chk("nmi_no_retrigger", 32'(cnt_nmi), 32'(NMI_LEN));
      wr(8'h01);
      cnt_nmi = 0; wr(8'h04); run(NMI_LEN + 4);
      chk("nmi_in_reset", 32'(cnt_nmi), 32'd0);
      chk("rstb_low_04",  32'(mcu_rstb), 32'd0);
      wr(8'h01);
      m_b2 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         b2 = 1'($urandom_range(0, 1));
         d  = {5'b0, b2, 2'b01};
         cnt_nmi = 0;
         wr(d);
         run(NMI_LEN + 3);
         chk("nmi_rand", 32'(cnt_nmi), (b2 && !m_b2) ? 32'(NMI_LEN) : 32'd0);
         m_b2 = b2;
      end

      // ---- auto halt handshake, grant seen at the g-th cen cycle ----
      wr(8'h09);
      clk1(); clk1();
      chk("status_auto", 32'(status), 32'h02);
      for (int i = 0; i < 4; i++) begin
         g = (g_tab[i] == 0) ? int'($urandom_range(3, 12)) : g_tab[i];
         com_cs   = 1'b1;
         mcu_ban  = (g == 1) ? 1'b0 : 1'b1;
         cnt_wait = 0;
         for (int k = 1; k <= g; k++) begin
            if (k == g) mcu_ban = 1'b0;
            cen_cyc();
         end
         run(3);
         // already-granted bus never stalls; otherwise the stall lasts
         // through the cycle in which the grant is first seen
         chk("auto_wait_len", 32'(cnt_wait), (g == 1) ? 32'd0 : 32'(g));
         chk("auto_wait_off", 32'(main_wait), 32'd0);
         chk("auto_halt_on",  32'(mcu_halt),  32'd1);
         com_cs = 1'b0;
         cen_cyc();
         cnt_halt = 0;
         run(HOLD_CYC + 4);
         chk("auto_hold_len", 32'(cnt_halt), 32'(HOLD_CYC));
         mcu_ban = 1'b1;
         run(2);
      end

      // ---- renewed access during hold restarts the hold time ----
      com_cs = 1'b1; mcu_ban = 1'b0;
      cen_cyc();
      com_cs = 1'b0; run(3);
      com_cs = 1'b1; cen_cyc();
      com_cs = 1'b0; cen_cyc();
      cnt_halt = 0;
      run(HOLD_CYC + 4);
      chk("hold_restart", 32'(cnt_halt), 32'(HOLD_CYC));

      // ---- MCU resumes while granted: stall comes back ----
      com_cs = 1'b1; mcu_ban = 1'b0;
      cen_cyc();
      mcu_ban = 1'b1;
      #1;
      chk("resume_wait_comb", 32'(main_wait), 32'd1);
      cen_cyc();
      chk("resume_wait_req", 32'(main_wait), 32'd1);
      chk("resume_halt",     32'(mcu_halt),  32'd1);
      mcu_ban = 1'b0;
      cen_cyc();
      chk("resume_regrant", 32'(main_wait), 32'd0);
      com_cs = 1'b0;
      run(HOLD_CYC + 3);
      chk("resume_release", 32'(mcu_halt), 32'd0);
      mcu_ban = 1'b1;
      run(1);

      // ---- software halt ----
      wr(8'h03);
      chk("sw_halt_on", 32'(mcu_halt), 32'd1);
      mcu_ban = 1'b0; com_cs = 1'b1; cnt_wait = 0;
      run(3);
      chk("sw_halt_no_wait", 32'(cnt_wait), 32'd0);
      com_cs = 1'b0;
      run(HOLD_CYC + 3);
      chk("sw_halt_kept", 32'(mcu_halt), 32'd1);
      mcu_ban = 1'b1;
      wr(8'h01);
      chk("sw_halt_off", 32'(mcu_halt), 32'd0);

      // ---- grant never arrives ----
      wr(8'h09);
      gap = 0;
      com_cs = 1'b1; mcu_ban = 1'b1;
      cen_cyc();                     // request cycle
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         cen_cyc();
         if (!s_wait) break;
         n++;
      end
      chk("timeout_len",  32'(n), 32'(TIMEOUT));
      clk1(); clk1();
      chk("timeout_status", 32'(status),   32'h0A);
      chk("timeout_halt",   32'(mcu_halt), 32'd0);
      com_cs = 1'b0;
      cen_cyc();
      wr(8'h09);
      clk1(); clk1();
      chk("timeout_clear", 32'(status), 32'h02);
      gap = 2;

      // ---- MCU interrupt ----
      mcu_irqmain = 1'b1;
      clk1();
      chk("irq_lat1", 32'(main_irq), 32'd0);
      clk1();
      chk("irq_lat2", 32'(main_irq), 32'd1);
      repeat (3) clk1();
      mcu_irqmain = 1'b0;
      clk1();
      chk("irq_latched", 32'(main_irq), 32'd1);
      clk1();
      chk("irq_status", 32'(status), 32'h06);
      mcu_irqmain = 1'b1; irq_ack = 1'b1;
      clk1();
      irq_ack = 1'b0;
      clk1();
      chk("irq_set_wins", 32'(main_irq), 32'd1);
      mcu_irqmain = 1'b0; irq_ack = 1'b1;
      clk1();
      irq_ack = 1'b0;
      clk1();
      chk("irq_acked", 32'(main_irq), 32'd0);

      irq_ack = 1'b1;
      clk1(); clk1();
      irq_ack = 1'b0;
      m_pend = 1'b0; m_prev = 1'b0;
      for (int i = 0; i < 40; i++) begin
         in_v  = 1'($urandom_range(0, 1));
         ack_v = ($urandom_range(0, 3) == 0);
         mcu_irqmain = in_v;
         irq_ack     = ack_v;
         clk1();
         exp_irq = m_pend;
         if (in_v && !m_prev) m_pend = 1'b1;
         else if (ack_v)      m_pend = 1'b0;
         m_prev = in_v;
         chk("irq_rand", 32'(main_irq), 32'(exp_irq));
      end
      mcu_irqmain = 1'b0; irq_ack = 1'b1;
      clk1(); clk1();
      irq_ack = 1'b0;

      // ---- asynchronous reset during a pending request ----
      wr(8'h0B);
      com_cs = 1'b1; mcu_ban = 1'b1;
      cen_cyc(); cen_cyc();
      chk("pre_rst_wait", 32'(main_wait), 32'd1);
      chk("pre_rst_halt", 32'(mcu_halt),  32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_wait", 32'(main_wait), 32'd0);
      chk("async_rst_halt", 32'(mcu_halt),  32'd0);
      chk("async_rst_rstb", 32'(mcu_rstb),  32'd0);
      clk1();
      rst = 1'b0; com_cs = 1'b0;
      clk1();
      chk("post_rst_rstb", 32'(mcu_rstb), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
